reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Parametrised multi-entry register file: the successor to the single N-bit load register.
- Ports: one synchronous write port and two registered read ports.
- Adds a synchronous bulk clear and an error flag for out-of-range addresses.
- Used as operand/scratch storage in datapath labs, e.g. a small ALU accumulator bank.

Parameters:
- N, 8, data width in bits (>=1)
- DEPTH, 4, number of entries (>=2; need not be a power of two)
- AW, $clog2(DEPTH), address width; derived, do not override

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of all entries
- we  input  1  write enable
- waddr  input  AW  write address
- wdata  input  N  write data
- re_a  input  1  read enable, port A
- raddr_a  input  AW  read address, port A
- rdata_a  output  N  registered read data, port A
- re_b  input  1  read enable, port B
- raddr_b  input  AW  read address, port B
- rdata_b  output  N  registered read data, port B
- addr_err  output  1  registered: an out-of-range address was used last cycle

Behaviour:
- Reset: rst=1 asynchronously clears all entries, rdata_a, rdata_b and addr_err to 0. Effect is immediate, independent of clk, including mid-operation. Outputs stay 0 while rst is held.
- Write: on posedge with we=1 and waddr<DEPTH, mem[waddr]<=wdata. Visible to reads launched on the next posedge.
- Read: on posedge with re_x=1, rdata_x<=mem[raddr_x] (1-cycle latency). With re_x=0, rdata_x holds its previous value.
- Read of an out-of-range address (raddr_x>=DEPTH) with re_x=1: rdata_x<=0.
- Both ports may read the same address in the same cycle; both return identical data.
- Read/write collision (same address, same edge), without bypass: read returns the OLD contents.
- clr=1 at posedge: all entries <=0. clr has priority over we, so a write in the same cycle is discarded.
- Reads in the clear cycle return pre-clear contents. The cycle after, they return 0.
- Out-of-range write (we=1, waddr>=DEPTH): write is dropped and memory is unchanged.
- addr_err: on each posedge, addr_err <= (we & waddr>=DEPTH) | (re_a & raddr_a>=DEPTH) | (re_b & raddr_b>=DEPTH).
  - It is a one-cycle pulse per offending cycle, not sticky.
  - It is always 0 when DEPTH is a power of two.
- No internal FSM. State is only the DEPTH x N array, two output registers and the error flag.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. If we=1, clr=0, waddr<DEPTH and re_x=1 with raddr_x==waddr on the same edge, rdata_x<=wdata (new data).
- Not defined: the collision returns old data, as stated above.
- clr still wins: with clr=1, no bypass occurs.

Decomposition:
- Package reg_file_pkg holds:
  - default constants RF_N_DEF=8 and RF_DEPTH_DEF=4
  - an address-width helper function
- Sub-module reg_file_entry holds one N-bit storage word.
  - Ports: clk, rst, clr, load, d, q.
  - rst is asynchronous to 0; clr has priority over load.
  - reg_file instantiates DEPTH copies via generate, with load = we & (waddr==i) & in-range.
- The read muxes and the error flag live in reg_file.

Test Plan (N=8, DEPTH=4 unless noted):
- Reset: assert rst mid-cycle after filling entries → rdata_a/rdata_b/addr_err go to 0 immediately without a clock edge. After release, reading all 4 addresses returns 8'h00.
- Write/read: write 8'h55@0, 8'hAA@1, 8'hFF@3 on consecutive edges. Then re_a=1,raddr_a=1 and re_b=1,raddr_b=3 → next edge rdata_a=8'hAA, rdata_b=8'hFF. Dropping re_a for one cycle holds 8'hAA.
- Collision: mem[2]=8'h11; write 8'h22@2 while re_a=1,raddr_a=2 → rdata_a=8'h11 without the macro, 8'h22 with REG_FILE_BYPASS_EN. The following read returns 8'h22 in both builds.
- Clear priority: mem[0]=8'h55; clr=1 and we=1,waddr=1,wdata=8'h77 on the same edge → subsequent reads of 0 and 1 both return 8'h00.
- Out-of-range (DEPTH=3): we=1,waddr=3,wdata=8'h99 → addr_err=1 for exactly one cycle and entries 0..2 are unchanged. re_b=1,raddr_b=3 → rdata_b=8'h00 and addr_err=1.
- Dual same-address read: mem[1]=8'h3C; raddr_a=raddr_b=1, both enabled → rdata_a=rdata_b=8'h3C on the next edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and the address-width helper for the register file.
// Latency: n/a (constants and an elaboration-time function only).
// Backpressure: n/a.
package reg_file_pkg;

   localparam int RF_N_DEF     = 8;
   localparam int RF_DEPTH_DEF = 4;

   // Smallest address width that can name every entry; never below one bit.
   function automatic int rf_addr_width(input int depth);
      int aw;
      aw = 1;
      while ((1 << aw) < depth) begin
         aw = aw + 1;
      end
      return aw;
   endfunction

endpackage

// File: rtl/reg_file_entry.sv
// reg_file_entry: one N-bit storage word of the register file.
// Latency: d captured on the rising edge when load=1; clr zeroes the word on the same edge.
// Backpressure: none; clr outranks load, rst clears asynchronously.
module reg_file_entry
   import reg_file_pkg::*;
#(
   parameter int N = RF_N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Storage word: async reset, then synchronous clear, then load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x N register file, one write port, two registered read ports, address error flag.
// Latency: reads return 1 cycle after re_x; writes are visible to reads launched on the next edge.
// Backpressure: none, every port accepts every cycle. Define REG_FILE_BYPASS_EN for same-edge write forwarding.
module reg_file
   import reg_file_pkg::*;
#(
   parameter  int N     = RF_N_DEF,
   parameter  int DEPTH = RF_DEPTH_DEF,
   localparam int AW    = rf_addr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [N-1:0]  wdata,
   input  logic          re_a,
   input  logic [AW-1:0] raddr_a,
   output logic [N-1:0]  rdata_a,
   input  logic          re_b,
   input  logic [AW-1:0] raddr_b,
   output logic [N-1:0]  rdata_b,
   output logic          addr_err
);

   // A power-of-two depth covers the whole address space, so nothing is ever out of range.
   localparam bit POW2 = (DEPTH == (1 << AW));

   logic          wr_ok;
   logic          rd_ok_a;
   logic          rd_ok_b;
   logic [N-1:0]  mem_q [DEPTH];
   logic [N-1:0]  rd_val_a;
   logic [N-1:0]  rd_val_b;
   logic          err_next;

   if (POW2) begin : g_range_full
      assign wr_ok   = 1'b1;
      assign rd_ok_a = 1'b1;
      assign rd_ok_b = 1'b1;
   end else begin : g_range_part
      localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
      assign wr_ok   = (waddr   <= LAST);
      assign rd_ok_a = (raddr_a <= LAST);
      assign rd_ok_b = (raddr_b <= LAST);
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(i);
      logic load;
      assign load = we & wr_ok & (waddr == IDX);
      reg_file_entry #(.N(N)) u_entry (
         .clk  (clk),
         .rst  (rst),
         .clr  (clr),
         .load (load),
         .d    (wdata),
         .q    (mem_q[i])
      );
   end

   assign err_next = (we & ~wr_ok) | (re_a & ~rd_ok_a) | (re_b & ~rd_ok_b);

   // Read muxes: an out-of-range address matches no entry and reads as 0; optional forwarding of wdata.
   always_comb begin
      rd_val_a = '0;
      rd_val_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr_a == AW'(i)) rd_val_a = mem_q[i];
         if (raddr_b == AW'(i)) rd_val_b = mem_q[i];
      end
`ifdef REG_FILE_BYPASS_EN
      // A clear in the same cycle suppresses forwarding; the read then sees the pre-clear word.
      if (we && !clr && wr_ok && (raddr_a == waddr)) rd_val_a = wdata;
      if (we && !clr && wr_ok && (raddr_b == waddr)) rd_val_b = wdata;
`else
      // Without forwarding a same-edge collision returns the old contents.
`endif
   end

   // Output registers: read data holds while re_x=0; addr_err pulses for one cycle per offence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_a  <= '0;
         rdata_b  <= '0;
         addr_err <= 1'b0;
      end else begin
         if (re_a) rdata_a <= rd_val_a;
         if (re_b) rdata_b <= rd_val_b;
         addr_err <= err_next;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed table plus hand sequences for a DEPTH=4 and a DEPTH=3 instance on shared inputs.
// Latency: one step = inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: n/a.
module tb_reg_file;

   typedef struct {
      logic       clr;
      logic       we;
      logic [1:0] waddr;
      logic [7:0] wdata;
      logic       re_a;
      logic [1:0] raddr_a;
      logic       re_b;
      logic [1:0] raddr_b;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
      logic       exp_err;
   } vec_t;

`ifdef REG_FILE_BYPASS_EN
   localparam logic [7:0] COLL = 8'h22;
`else
   localparam logic [7:0] COLL = 8'h11;
`endif

   logic       clk;
   logic       rst;
   logic       clr;
   logic       we;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic       re_a;
   logic [1:0] raddr_a;
   logic       re_b;
   logic [1:0] raddr_b;
   logic [7:0] d4_rdata_a;
   logic [7:0] d4_rdata_b;
   logic       d4_err;
   logic [7:0] d3_rdata_a;
   logic [7:0] d3_rdata_b;
   logic       d3_err;

   int n_pass;
   int n_total;

   reg_file #(.N(8), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(d4_rdata_a),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(d4_rdata_b),
      .addr_err(d4_err)
   );

   reg_file #(.N(8), .DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .re_a(re_a), .raddr_a(raddr_a), .rdata_a(d3_rdata_a),
      .re_b(re_b), .raddr_b(raddr_b), .rdata_b(d3_rdata_b),
      .addr_err(d3_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic c, input logic w, input logic [1:0] wa, input logic [7:0] wd,
                               input logic ra_en, input logic [1:0] ra, input logic rb_en, input logic [1:0] rb,
                               input logic [7:0] ea, input logic [7:0] eb, input logic ee);
      vec_t v;
      v.clr = c;      v.we = w;         v.waddr = wa;   v.wdata = wd;
      v.re_a = ra_en; v.raddr_a = ra;   v.re_b = rb_en; v.raddr_b = rb;
      v.exp_a = ea;   v.exp_b = eb;     v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total = n_total + 1;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end else begin
         n_pass = n_pass + 1;
      end
   endtask

   task automatic drive(input vec_t v);
      clr = v.clr;   we = v.we;           waddr = v.waddr; wdata = v.wdata;
      re_a = v.re_a; raddr_a = v.raddr_a; re_b = v.re_b;   raddr_b = v.raddr_b;
   endtask

   // Drive one vector, let one rising edge take it, sample just after the edge.
   task automatic step(input vec_t v);
      drive(v);
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];
   vec_t idle;

   initial begin
      n_pass  = 0;
      n_total = 0;
      idle = mk(0, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0);
      drive(idle);
      rst = 1'b1;

      //        clr we wa  wdata  rea ra  reb rb  exp_a  exp_b  err
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd1, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd2, 1, 2'd3, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(0, 1, 2'd0, 8'h55, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(0, 1, 2'd1, 8'hAA, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(0, 1, 2'd3, 8'hFF, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd1, 1, 2'd3, 8'hAA, 8'hFF, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd0, 8'hAA, 8'h55, 1'b0));
      tbl.push_back(mk(0, 1, 2'd2, 8'h11, 1, 2'd0, 0, 2'd0, 8'h55, 8'h55, 1'b0));
      tbl.push_back(mk(0, 1, 2'd2, 8'h22, 1, 2'd2, 0, 2'd0, COLL,  8'h55, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd2, 0, 2'd0, 8'h22, 8'h55, 1'b0));
      tbl.push_back(mk(0, 1, 2'd1, 8'h3C, 0, 2'd0, 0, 2'd0, 8'h22, 8'h55, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd1, 1, 2'd1, 8'h3C, 8'h3C, 1'b0));
      tbl.push_back(mk(1, 1, 2'd1, 8'h77, 1, 2'd0, 1, 2'd1, 8'h55, 8'h3C, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd1, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd3, 1, 2'd2, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(0, 1, 2'd2, 8'h66, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      tbl.push_back(mk(1, 1, 2'd2, 8'h44, 1, 2'd2, 0, 2'd0, 8'h66, 8'h00, 1'b0));
      tbl.push_back(mk(0, 0, 2'd0, 8'h00, 1, 2'd2, 0, 2'd0, 8'h00, 8'h00, 1'b0));

      // Reset state, before any clock edge.
      #2;
      chk("reset_rdata_a", d4_rdata_a, 8'h00);
      chk("reset_rdata_b", d4_rdata_b, 8'h00);
      chk("reset_addr_err", {7'd0, d4_err}, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i]);
         chk($sformatf("vec%0d_rdata_a", i), d4_rdata_a, tbl[i].exp_a);
         chk($sformatf("vec%0d_rdata_b", i), d4_rdata_b, tbl[i].exp_b);
         chk($sformatf("vec%0d_addr_err", i), {7'd0, d4_err}, {7'd0, tbl[i].exp_err});
      end

      // Asynchronous reset mid-cycle after loading data and raising an error pulse.
      step(mk(0, 1, 2'd0, 8'hA5, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      step(mk(0, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd3, 8'h00, 8'h00, 1'b0));
      chk("pre_rst_rdata_a", d4_rdata_a, 8'hA5);
      chk("pre_rst_d3_err", {7'd0, d3_err}, 8'h01);
      drive(idle);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_rdata_a", d4_rdata_a, 8'h00);
      chk("async_rst_d3_err", {7'd0, d3_err}, 8'h00);
      @(posedge clk);
      #1;
      chk("rst_held_rdata_a", d4_rdata_a, 8'h00);
      rst = 1'b0;
      step(mk(0, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd1, 8'h00, 8'h00, 1'b0));
      chk("post_rst_rd0", d4_rdata_a, 8'h00);
      chk("post_rst_rd1", d4_rdata_b, 8'h00);
      step(mk(0, 0, 2'd0, 8'h00, 1, 2'd2, 1, 2'd3, 8'h00, 8'h00, 1'b0));
      chk("post_rst_rd2", d4_rdata_a, 8'h00);
      chk("post_rst_rd3", d4_rdata_b, 8'h00);

      // Out-of-range handling on the DEPTH=3 instance.
      step(mk(0, 1, 2'd0, 8'h01, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      step(mk(0, 1, 2'd1, 8'h02, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      step(mk(0, 1, 2'd2, 8'h03, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      step(mk(0, 1, 2'd3, 8'h99, 0, 2'd0, 0, 2'd0, 8'h00, 8'h00, 1'b0));
      chk("oor_wr_d3_err", {7'd0, d3_err}, 8'h01);
      chk("oor_wr_d4_err", {7'd0, d4_err}, 8'h00);
      step(idle);
      chk("oor_wr_err_pulse", {7'd0, d3_err}, 8'h00);
      step(mk(0, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd1, 8'h00, 8'h00, 1'b0));
      chk("oor_keep_e0", d3_rdata_a, 8'h01);
      chk("oor_keep_e1", d3_rdata_b, 8'h02);
      chk("oor_rd_ok_err", {7'd0, d3_err}, 8'h00);
      step(mk(0, 0, 2'd0, 8'h00, 1, 2'd2, 1, 2'd2, 8'h00, 8'h00, 1'b0));
      chk("oor_keep_e2_a", d3_rdata_a, 8'h03);
      chk("oor_keep_e2_b", d3_rdata_b, 8'h03);
      step(mk(0, 0, 2'd0, 8'h00, 0, 2'd0, 1, 2'd3, 8'h00, 8'h00, 1'b0));
      chk("oor_rd_zero", d3_rdata_b, 8'h00);
      chk("oor_rd_err", {7'd0, d3_err}, 8'h01);
      chk("oor_rd_hold_a", d3_rdata_a, 8'h03);
      chk("d4_rd3_val", d4_rdata_b, 8'h99);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
